// File: rtl/uctl_cmdarb_pkg.sv
// Shared encodings for the USB controller command-interface arbiter.
package uctl_cmdarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CMD  = 2'b01,
        WR   = 2'b10,
        RD   = 2'b11
    } state_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_e;

    localparam int ADDR_INCR_DEF = 4;

endpackage

// File: rtl/uctl_rr_arb2.sv
// Two-request picker. UCTL_CMDARB_RR_EN selects round-robin with a last-owner
// register; otherwise fixed priority with m0 winning.
module uctl_rr_arb2
    import uctl_cmdarb_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   sw_rst,
    input  logic   req0,
    input  logic   req1,
    input  logic   take,
    output owner_e winner,
    output logic   any_req
);

    assign any_req = req0 | req1;

`ifdef UCTL_CMDARB_RR_EN
    owner_e last_owner_q;
    owner_e last_owner_d;

    always_comb begin
        winner = M0;
        if (req0 && req1) begin
            winner = (last_owner_q == M0) ? M1 : M0;
        end else if (req1) begin
            winner = M1;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (sw_rst) begin
            last_owner_d = M1;
        end else if (take) begin
            last_owner_d = winner;
        end
    end

    // m1 is "last" out of reset so the first tie goes to m0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= M1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    logic unused_ok;

    always_comb begin
        winner = (!req0 && req1) ? M1 : M0;
    end

    assign unused_ok = ^{clk, rst_n, sw_rst, take};
`endif

endmodule

// File: rtl/uctl_cmd_arbiter.sv
// Two-master burst arbiter/sequencer in front of the USB controller cmdIf.
// Define UCTL_CMDARB_RR_EN for round-robin arbitration (default: m0 priority).
module uctl_cmd_arbiter
    import uctl_cmdarb_pkg::*;
#(
    parameter int LEN_W     = 8,
    parameter int ADDR_INCR = ADDR_INCR_DEF
) (
    input  logic             sys_clk,
    input  logic             sysRst_n,
    input  logic             sw_rst,
    input  logic             m0_req,
    input  logic [31:0]      m0_addr,
    input  logic             m0_wrRd,
    input  logic [LEN_W-1:0] m0_len,
    output logic             m0_gnt,
    input  logic [31:0]      m0_wrData,
    input  logic             m0_wrValid,
    output logic             m0_wrAck,
    output logic [31:0]      m0_rdData,
    output logic             m0_rdValid,
    output logic             m0_done,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic [31:0]      m1_addr,
    input  logic             m1_wrRd,
    input  logic [LEN_W-1:0] m1_len,
    output logic             m1_gnt,
    input  logic [31:0]      m1_wrData,
    input  logic             m1_wrValid,
    output logic             m1_wrAck,
    output logic [31:0]      m1_rdData,
    output logic             m1_rdValid,
    output logic             m1_done,
    output logic             m1_err,
    output logic             cmdIf_trEn,
    output logic             cmdIf_req,
    output logic [31:0]      cmdIf_addr,
    output logic             cmdIf_wrRd,
    input  logic             cmdIf_ack,
    output logic             cmdIf_wrData_req,
    output logic [31:0]      cmdIf_wrData,
    input  logic             cmdIf_wrData_ack,
    output logic             cmdIf_rdData_req,
    input  logic             cmdIf_rdData_ack,
    input  logic [31:0]      cmdIf_rdData
);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [31:0]      cur_addr_q, cur_addr_d;
    logic             dir_q, dir_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;

    owner_e           winner;
    logic             any_req;
    logic             take;
    logic [31:0]      sel_addr;
    logic             sel_wr_rd;
    logic [LEN_W-1:0] sel_len;
    logic             own_wr_valid;
    logic [31:0]      own_wr_data;
    logic [1:0]       gnt_c, wr_ack_c, rd_valid_c;

    // No grant while either reset is active, so reset really leaves all outputs low.
    assign take = (state_q == IDLE) && any_req && sysRst_n && !sw_rst;

    uctl_rr_arb2 u_arb (
        .clk     (sys_clk),
        .rst_n   (sysRst_n),
        .sw_rst  (sw_rst),
        .req0    (m0_req),
        .req1    (m1_req),
        .take    (take),
        .winner  (winner),
        .any_req (any_req)
    );

    assign sel_addr     = (winner == M1) ? m1_addr    : m0_addr;
    assign sel_wr_rd    = (winner == M1) ? m1_wrRd    : m0_wrRd;
    assign sel_len      = (winner == M1) ? m1_len     : m0_len;
    assign own_wr_valid = (owner_q == M1) ? m1_wrValid : m0_wrValid;
    assign own_wr_data  = (owner_q == M1) ? m1_wrData  : m0_wrData;

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        cur_addr_d       = cur_addr_q;
        dir_d            = dir_q;
        cnt_d            = cnt_q;
        done_d           = '0;
        err_d            = '0;
        gnt_c            = '0;
        wr_ack_c         = '0;
        rd_valid_c       = '0;
        cmdIf_trEn       = 1'b0;
        cmdIf_req        = 1'b0;
        cmdIf_addr       = '0;
        cmdIf_wrRd       = 1'b0;
        cmdIf_wrData_req = 1'b0;
        cmdIf_wrData     = '0;
        cmdIf_rdData_req = 1'b0;

        case (state_q)
            IDLE: begin
                if (take) begin
                    gnt_c[winner] = 1'b1;
                    owner_d       = winner;
                    cur_addr_d    = sel_addr;
                    dir_d         = sel_wr_rd;
                    cnt_d         = (sel_len == '0) ? LEN_W'(1) : sel_len;
                    state_d       = CMD;
                end
            end
            CMD: begin
                cmdIf_trEn = 1'b1;
                cmdIf_req  = 1'b1;
                cmdIf_addr = cur_addr_q;
                cmdIf_wrRd = dir_q;
                if (cmdIf_ack) begin
                    state_d = dir_q ? WR : RD;
                end else begin
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    state_d         = IDLE;
                end
            end
            WR: begin
                cmdIf_trEn = 1'b1;
                cmdIf_addr = cur_addr_q;
                cmdIf_wrRd = dir_q;
                if (own_wr_valid) begin
                    cmdIf_wrData_req = 1'b1;
                    cmdIf_wrData     = own_wr_data;
                    if (cmdIf_wrData_ack) begin
                        wr_ack_c[owner_q] = 1'b1;
                        cur_addr_d        = cur_addr_q + 32'(ADDR_INCR);
                        cnt_d             = cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            done_d[owner_q] = 1'b1;
                            state_d         = IDLE;
                        end
                    end
                end else begin
                    // Stalled write: re-issue the command so the decoder stays out of IDLE.
                    cmdIf_req = 1'b1;
                    if (!cmdIf_ack) begin
                        done_d[owner_q] = 1'b1;
                        err_d[owner_q]  = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            RD: begin
                cmdIf_trEn       = 1'b1;
                cmdIf_addr       = cur_addr_q;
                cmdIf_wrRd       = dir_q;
                cmdIf_rdData_req = 1'b1;
                if (cmdIf_rdData_ack) begin
                    rd_valid_c[owner_q] = 1'b1;
                    cur_addr_d          = cur_addr_q + 32'(ADDR_INCR);
                    cnt_d               = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        done_d[owner_q] = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
        endcase

        if (sw_rst) begin
            state_d    = IDLE;
            owner_d    = M0;
            cur_addr_d = '0;
            dir_d      = 1'b0;
            cnt_d      = '0;
            done_d     = '0;
            err_d      = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            state_q    <= IDLE;
            owner_q    <= M0;
            cur_addr_q <= '0;
            dir_q      <= 1'b0;
            cnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cur_addr_q <= cur_addr_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign m0_gnt     = gnt_c[0];
    assign m1_gnt     = gnt_c[1];
    assign m0_wrAck   = wr_ack_c[0];
    assign m1_wrAck   = wr_ack_c[1];
    assign m0_rdValid = rd_valid_c[0];
    assign m1_rdValid = rd_valid_c[1];
    assign m0_rdData  = cmdIf_rdData;
    assign m1_rdData  = cmdIf_rdData;
    assign m0_done    = done_q[0];
    assign m1_done    = done_q[1];
    assign m0_err     = err_q[0];
    assign m1_err     = err_q[1];

endmodule

// File: tb/tb_uctl_cmd_arbiter.sv
// Directed bench for uctl_cmd_arbiter; expectations follow UCTL_CMDARB_RR_EN.
module tb_uctl_cmd_arbiter;

    logic        sys_clk = 1'b0;
    logic        sysRst_n, sw_rst;
    logic        m0_req, m1_req, m0_wrRd, m1_wrRd, m0_wrValid, m1_wrValid;
    logic [31:0] m0_addr, m1_addr, m0_wrData, m1_wrData;
    logic [7:0]  m0_len, m1_len;
    logic        m0_gnt, m1_gnt, m0_wrAck, m1_wrAck, m0_rdValid, m1_rdValid;
    logic        m0_done, m1_done, m0_err, m1_err;
    logic [31:0] m0_rdData, m1_rdData;
    logic        cmdIf_trEn, cmdIf_req, cmdIf_wrRd, cmdIf_ack;
    logic [31:0] cmdIf_addr, cmdIf_wrData, cmdIf_rdData;
    logic        cmdIf_wrData_req, cmdIf_wrData_ack, cmdIf_rdData_req, cmdIf_rdData_ack;

    logic [1:0]  gnt;
    logic [3:0]  cmdv, mst;
    int          total = 0;
    int          bad   = 0;

    assign gnt  = {m0_gnt, m1_gnt};
    assign cmdv = {cmdIf_trEn, cmdIf_req, cmdIf_wrData_req, cmdIf_rdData_req};
    assign mst  = {m0_done, m0_err, m1_done, m1_err};

    always #5 sys_clk = ~sys_clk;

    uctl_cmd_arbiter dut (
        .sys_clk(sys_clk), .sysRst_n(sysRst_n), .sw_rst(sw_rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wrRd(m0_wrRd), .m0_len(m0_len),
        .m0_gnt(m0_gnt), .m0_wrData(m0_wrData), .m0_wrValid(m0_wrValid),
        .m0_wrAck(m0_wrAck), .m0_rdData(m0_rdData), .m0_rdValid(m0_rdValid),
        .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wrRd(m1_wrRd), .m1_len(m1_len),
        .m1_gnt(m1_gnt), .m1_wrData(m1_wrData), .m1_wrValid(m1_wrValid),
        .m1_wrAck(m1_wrAck), .m1_rdData(m1_rdData), .m1_rdValid(m1_rdValid),
        .m1_done(m1_done), .m1_err(m1_err),
        .cmdIf_trEn(cmdIf_trEn), .cmdIf_req(cmdIf_req), .cmdIf_addr(cmdIf_addr),
        .cmdIf_wrRd(cmdIf_wrRd), .cmdIf_ack(cmdIf_ack),
        .cmdIf_wrData_req(cmdIf_wrData_req), .cmdIf_wrData(cmdIf_wrData),
        .cmdIf_wrData_ack(cmdIf_wrData_ack), .cmdIf_rdData_req(cmdIf_rdData_req),
        .cmdIf_rdData_ack(cmdIf_rdData_ack), .cmdIf_rdData(cmdIf_rdData)
    );

    task automatic nxt();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        m0_req = 1'b1;
        cmdIf_rdData = 32'h1234_5678;
        @(negedge sys_clk);
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b exp=00", gnt); end
        total++; if (cmdv !== 4'b0000) begin bad++; $display("FAIL rst_cmd got=%b exp=0000", cmdv); end
        total++; if (mst !== 4'b0000) begin bad++; $display("FAIL rst_done got=%b exp=0000", mst); end
        total++; if (cmdIf_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", cmdIf_addr); end
        total++; if ({m0_rdData, m1_rdData} !== {32'h1234_5678, 32'h1234_5678}) begin
            bad++; $display("FAIL rst_rddata got=%h/%h exp=12345678", m0_rdData, m1_rdData);
        end
        sysRst_n = 1'b1;
        m0_req   = 1'b0;
        nxt();
    endtask

    task automatic test_write();
        m0_addr = 32'h0920; m0_wrRd = 1'b1; m0_len = 8'd3; m0_wrValid = 1'b1;
        m0_wrData = 32'hD000_0000; cmdIf_ack = 1'b1; cmdIf_wrData_ack = 1'b1; m0_req = 1'b1;
        @(negedge sys_clk);
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL wr_gnt got=%b exp=10", gnt); end
        total++; if (cmdv !== 4'b0000) begin bad++; $display("FAIL wr_idle got=%b exp=0000", cmdv); end
        nxt(); m0_req = 1'b0;
        @(negedge sys_clk);
        total++; if (cmdv !== 4'b1100) begin bad++; $display("FAIL wr_cmd got=%b exp=1100", cmdv); end
        total++; if ({cmdIf_addr, cmdIf_wrRd} !== {32'h0920, 1'b1}) begin
            bad++; $display("FAIL wr_cmd_addr got=%h/%b exp=920/1", cmdIf_addr, cmdIf_wrRd);
        end
        for (int i = 0; i < 3; i++) begin
            nxt(); m0_wrData = 32'hD000_0000 + 32'(i);
            @(negedge sys_clk);
            total++; if (cmdv !== 4'b1010) begin bad++; $display("FAIL wr_beat%0d got=%b exp=1010", i, cmdv); end
            total++; if (cmdIf_addr !== 32'h0920 + 32'(4 * i)) begin
                bad++; $display("FAIL wr_addr%0d got=%h exp=%h", i, cmdIf_addr, 32'h0920 + 32'(4 * i));
            end
            total++; if (cmdIf_wrData !== 32'hD000_0000 + 32'(i)) begin
                bad++; $display("FAIL wr_data%0d got=%h exp=%h", i, cmdIf_wrData, 32'hD000_0000 + 32'(i));
            end
            total++; if ({m0_wrAck, m1_wrAck} !== 2'b10) begin
                bad++; $display("FAIL wr_ack%0d got=%b exp=10", i, {m0_wrAck, m1_wrAck});
            end
        end
        nxt(); m0_wrValid = 1'b0;
        @(negedge sys_clk);
        total++; if (mst !== 4'b1000) begin bad++; $display("FAIL wr_done got=%b exp=1000", mst); end
        total++; if (cmdv !== 4'b0000) begin bad++; $display("FAIL wr_end got=%b exp=0000", cmdv); end
        nxt();
        @(negedge sys_clk);
        total++; if (mst !== 4'b0000) begin bad++; $display("FAIL wr_done_pulse got=%b exp=0000", mst); end
        nxt();
    endtask

    task automatic test_read();
        m1_addr = 32'h0800; m1_wrRd = 1'b0; m1_len = 8'd2; m1_req = 1'b1;
        cmdIf_ack = 1'b1; cmdIf_rdData_ack = 1'b0;
        @(negedge sys_clk);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rd_gnt got=%b exp=01", gnt); end
        nxt(); m1_req = 1'b0;
        @(negedge sys_clk);
        total++; if ({cmdv, cmdIf_wrRd, cmdIf_addr} !== {4'b1100, 1'b0, 32'h0800}) begin
            bad++; $display("FAIL rd_cmd got=%b/%b/%h exp=1100/0/800", cmdv, cmdIf_wrRd, cmdIf_addr);
        end
        nxt();
        @(negedge sys_clk);
        total++; if ({cmdv, m1_rdValid} !== {4'b1001, 1'b0}) begin
            bad++; $display("FAIL rd_first_req got=%b/%b exp=1001/0", cmdv, m1_rdValid);
        end
        for (int w = 1; w <= 2; w++) begin
            nxt(); cmdIf_rdData_ack = 1'b1; cmdIf_rdData = 32'hA5A5_0000 + 32'(w);
            @(negedge sys_clk);
            total++; if ({m0_rdValid, m1_rdValid} !== 2'b01) begin
                bad++; $display("FAIL rd_valid%0d got=%b exp=01", w, {m0_rdValid, m1_rdValid});
            end
            total++; if (m1_rdData !== 32'hA5A5_0000 + 32'(w)) begin
                bad++; $display("FAIL rd_data%0d got=%h exp=%h", w, m1_rdData, 32'hA5A5_0000 + 32'(w));
            end
            nxt(); cmdIf_rdData_ack = 1'b0;
            @(negedge sys_clk);
            if (w == 1) begin
                total++; if ({cmdv, m1_rdValid} !== {4'b1001, 1'b0}) begin
                    bad++; $display("FAIL rd_gap got=%b/%b exp=1001/0", cmdv, m1_rdValid);
                end
            end else begin
                total++; if ({mst, cmdv} !== {4'b0010, 4'b0000}) begin
                    bad++; $display("FAIL rd_done got=%b/%b exp=0010/0000", mst, cmdv);
                end
            end
        end
        nxt();
    endtask

    task automatic test_arbitrate();
        logic [1:0] exp_gnt2;
        logic [3:0] exp_mst2;
`ifdef UCTL_CMDARB_RR_EN
        exp_gnt2 = 2'b01; exp_mst2 = 4'b0011;
`else
        exp_gnt2 = 2'b10; exp_mst2 = 4'b1100;
`endif
        m0_addr = 32'h0100; m1_addr = 32'h0100; m0_wrRd = 1'b0; m1_wrRd = 1'b0;
        m0_len = 8'd1; m1_len = 8'd1; cmdIf_ack = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
        @(negedge sys_clk);
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL arb_gnt1 got=%b exp=10", gnt); end
        nxt();
        @(negedge sys_clk);
        total++; if ({gnt, cmdv} !== {2'b00, 4'b1100}) begin
            bad++; $display("FAIL arb_busy got=%b/%b exp=00/1100", gnt, cmdv);
        end
        nxt();
        @(negedge sys_clk);
        total++; if (mst !== 4'b1100) begin bad++; $display("FAIL arb_abort1 got=%b exp=1100", mst); end
        total++; if (gnt !== exp_gnt2) begin bad++; $display("FAIL arb_gnt2 got=%b exp=%b", gnt, exp_gnt2); end
        nxt(); m0_req = 1'b0; m1_req = 1'b0;
        nxt();
        @(negedge sys_clk);
        total++; if (mst !== exp_mst2) begin bad++; $display("FAIL arb_abort2 got=%b exp=%b", mst, exp_mst2); end
        nxt();
    endtask

    task automatic test_unmapped();
        m1_addr = 32'h0000_0100; m1_wrRd = 1'b1; m1_len = 8'd1; m1_wrValid = 1'b1;
        m1_wrData = 32'hBEEF_0001; cmdIf_ack = 1'b0; m1_req = 1'b1;
        @(negedge sys_clk);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL um_gnt got=%b exp=01", gnt); end
        nxt(); m1_req = 1'b0;
        @(negedge sys_clk);
        total++; if ({cmdv, cmdIf_addr} !== {4'b1100, 32'h0100}) begin
            bad++; $display("FAIL um_cmd got=%b/%h exp=1100/100", cmdv, cmdIf_addr);
        end
        nxt();
        @(negedge sys_clk);
        total++; if ({mst, cmdv} !== {4'b0011, 4'b0000}) begin
            bad++; $display("FAIL um_err got=%b/%b exp=0011/0000", mst, cmdv);
        end
        nxt(); m1_wrValid = 1'b0;
    endtask

    task automatic test_stall();
        m0_addr = 32'h4000; m0_wrRd = 1'b1; m0_len = 8'd2; m0_wrValid = 1'b1;
        m0_wrData = 32'h1111_0001; cmdIf_ack = 1'b1; cmdIf_wrData_ack = 1'b1; m0_req = 1'b1;
        @(negedge sys_clk);
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL st_gnt got=%b exp=10", gnt); end
        nxt(); m0_req = 1'b0;
        nxt();
        @(negedge sys_clk);
        total++; if ({cmdv, cmdIf_addr} !== {4'b1010, 32'h4000}) begin
            bad++; $display("FAIL st_w1 got=%b/%h exp=1010/4000", cmdv, cmdIf_addr);
        end
        for (int s = 0; s < 3; s++) begin
            nxt(); m0_wrValid = 1'b0;
            @(negedge sys_clk);
            total++; if ({cmdv, cmdIf_addr, m0_wrAck} !== {4'b1100, 32'h4004, 1'b0}) begin
                bad++; $display("FAIL st_reissue%0d got=%b/%h/%b exp=1100/4004/0", s, cmdv, cmdIf_addr, m0_wrAck);
            end
        end
        nxt(); m0_wrValid = 1'b1; m0_wrData = 32'h1111_0002;
        @(negedge sys_clk);
        total++; if ({cmdv, cmdIf_addr, cmdIf_wrData, m0_wrAck} !== {4'b1010, 32'h4004, 32'h1111_0002, 1'b1}) begin
            bad++; $display("FAIL st_w2 got=%b/%h/%h/%b exp=1010/4004/11110002/1", cmdv, cmdIf_addr, cmdIf_wrData, m0_wrAck);
        end
        nxt(); m0_wrValid = 1'b0;
        @(negedge sys_clk);
        total++; if (mst !== 4'b1000) begin bad++; $display("FAIL st_done got=%b exp=1000", mst); end
        nxt();
    endtask

    task automatic test_wrap();
        m0_addr = 32'hFFFF_FFFC; m0_wrRd = 1'b1; m0_len = 8'd2; m0_wrValid = 1'b1;
        m0_wrData = 32'h2222_0001; cmdIf_ack = 1'b1; cmdIf_wrData_ack = 1'b1; m0_req = 1'b1;
        nxt(); m0_req = 1'b0;
        nxt();
        @(negedge sys_clk);
        total++; if ({cmdv, cmdIf_addr} !== {4'b1010, 32'hFFFF_FFFC}) begin
            bad++; $display("FAIL wrap_w1 got=%b/%h exp=1010/fffffffc", cmdv, cmdIf_addr);
        end
        nxt(); m0_wrValid = 1'b0; cmdIf_ack = 1'b0;
        @(negedge sys_clk);
        total++; if ({cmdv, cmdIf_addr} !== {4'b1100, 32'h0}) begin
            bad++; $display("FAIL wrap_addr got=%b/%h exp=1100/0", cmdv, cmdIf_addr);
        end
        nxt();
        @(negedge sys_clk);
        total++; if (mst !== 4'b1100) begin bad++; $display("FAIL wrap_err got=%b exp=1100", mst); end
        nxt();
    endtask

    task automatic test_sw_rst();
        m0_addr = 32'h0200; m0_wrRd = 1'b0; m0_len = 8'd4; cmdIf_ack = 1'b1;
        cmdIf_rdData_ack = 1'b0; m0_req = 1'b1;
        nxt(); m0_req = 1'b0;
        nxt();
        nxt(); cmdIf_rdData_ack = 1'b1; cmdIf_rdData = 32'hA5A5_0001;
        @(negedge sys_clk);
        total++; if ({m0_rdValid, m0_rdData} !== {1'b1, 32'hA5A5_0001}) begin
            bad++; $display("FAIL sr_word1 got=%b/%h exp=1/a5a50001", m0_rdValid, m0_rdData);
        end
        nxt(); cmdIf_rdData_ack = 1'b0; sw_rst = 1'b1;
        @(negedge sys_clk);
        total++; if (cmdv !== 4'b1001) begin bad++; $display("FAIL sr_inrd got=%b exp=1001", cmdv); end
        nxt(); sw_rst = 1'b0;
        m0_addr = 32'h0300; m0_wrRd = 1'b1; m0_len = 8'd1; m0_req = 1'b1;
        @(negedge sys_clk);
        total++; if ({cmdv, mst} !== {4'b0000, 4'b0000}) begin
            bad++; $display("FAIL sr_idle got=%b/%b exp=0000/0000", cmdv, mst);
        end
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL sr_regnt got=%b exp=10", gnt); end
        nxt(); m0_req = 1'b0; cmdIf_ack = 1'b0;
        @(negedge sys_clk);
        total++; if ({cmdv, cmdIf_addr, cmdIf_wrRd} !== {4'b1100, 32'h0300, 1'b1}) begin
            bad++; $display("FAIL sr_newcmd got=%b/%h/%b exp=1100/300/1", cmdv, cmdIf_addr, cmdIf_wrRd);
        end
        nxt();
        @(negedge sys_clk);
        total++; if (mst !== 4'b1100) begin bad++; $display("FAIL sr_abort got=%b exp=1100", mst); end
        nxt();
    endtask

    initial begin
        sysRst_n = 1'b0; sw_rst = 1'b0;
        m0_req = 1'b0; m0_addr = '0; m0_wrRd = 1'b0; m0_len = '0; m0_wrData = '0; m0_wrValid = 1'b0;
        m1_req = 1'b0; m1_addr = '0; m1_wrRd = 1'b0; m1_len = '0; m1_wrData = '0; m1_wrValid = 1'b0;
        cmdIf_ack = 1'b0; cmdIf_wrData_ack = 1'b0; cmdIf_rdData_ack = 1'b0; cmdIf_rdData = '0;
        repeat (2) @(posedge sys_clk);
        test_reset();
        test_write();
        test_read();
        test_arbitrate();
        test_unmapped();
        test_stall();
        test_wrap();
        test_sw_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uctl_cmd_arbiter.md
Name: uctl_cmd_arbiter

Overview:
- Two-master arbiter and sequencer in front of the USB controller command interface (cmdIf_*).
- Sources: m0 = AHB host bridge, m1 = internal DMA engine.
- Grants one master per burst, then issues the command phase and the per-word write/read data phases.
- Tracks the running address, so a stalled write keeps the downstream decoder out of IDLE by re-issuing the command.

Parameters:
LEN_W, 8, width of burst length (words) per master
ADDR_INCR, 4, byte increment per data word

Ports:
sys_clk  in  1  system clock
sysRst_n  in  1  asynchronous active-low reset
sw_rst  in  1  synchronous soft reset
m0_req / m1_req  in  1  burst request, held until gnt
m0_addr / m1_addr  in  32  start byte address
m0_wrRd / m1_wrRd  in  1  1=write, 0=read
m0_len / m1_len  in  LEN_W  word count (0 treated as 1)
m0_gnt / m1_gnt  out  1  one-cycle grant pulse
m0_wrData / m1_wrData  in  32  write word
m0_wrValid / m1_wrValid  in  1  write word available
m0_wrAck / m1_wrAck  out  1  write word consumed
m0_rdData / m1_rdData  out  32  read word (shared cmdIf_rdData)
m0_rdValid / m1_rdValid  out  1  read word valid, no backpressure
m0_done / m1_done  out  1  registered pulse, burst finished
m0_err / m1_err  out  1  registered pulse with done, burst aborted
cmdIf_trEn  out  1  transfer enable
cmdIf_req  out  1  command request
cmdIf_addr  out  32  command address
cmdIf_wrRd  out  1  direction
cmdIf_ack  in  1  same-cycle command accept
cmdIf_wrData_req  out  1  write data request
cmdIf_wrData  out  32  write data
cmdIf_wrData_ack  in  1  same-cycle write accept
cmdIf_rdData_req  out  1  read data request
cmdIf_rdData_ack  in  1  registered read ack
cmdIf_rdData  in  32  read data, valid with ack

Behaviour:
- Reset (async or sw_rst): state IDLE, owner=m0, last_owner=m1, cnt=0. All outputs 0; rdData follows cmdIf_rdData.
- sw_rst mid-burst: next cycle IDLE, no done/err.
- Outputs to cmdIf depend only on state registers and master inputs, never combinationally on cmdIf acks.
- IDLE (trEn=0):
  - If any m?_req is high, select a winner and pulse its gnt.
  - Latch addr, wrRd and len (0→1) into cur_addr, dir and cnt.
  - Go to CMD.
  - Arbitration happens only in IDLE; bursts are atomic.
- CMD (trEn=1, req=1, addr=cur_addr, wrRd=dir):
  - If cmdIf_ack, go to WR or RD.
  - Otherwise (unmapped address) set done+err for the owner, then go to IDLE.
- WR (trEn=1):
  - Owner wrValid=1: drive wrData_req=1 and wrData=owner data.
  - On wrData_ack: pulse wrAck, cur_addr+=ADDR_INCR (mod 2^32), cnt-=1. If cnt was 1, set done and go to IDLE.
  - Owner wrValid=0: drive cmdIf_req=1 with cur_addr. Without cmdIf_ack, set done+err and go to IDLE.
- RD (trEn=1, rdData_req held):
  - On rdData_ack: pulse rdValid (data=cmdIf_rdData), cur_addr+=ADDR_INCR, cnt-=1. If cnt was 1, set done and go to IDLE.
  - Steady throughput is 1 word per 2 cycles.
- Latency:
  - req high in IDLE at cycle 0: gnt at cycle 0, CMD at cycle 1, first wrData_req or rdData_req at cycle 2.
  - done/err at cycle N+1 after the final beat.
- Back-to-back bursts: at least one IDLE cycle between bursts (trEn=0 returns the downstream decoder to IDLE).
- Address wrap past 0xFFFF_FFFC wraps to 0. The next re-issue then fails and raises err.
- No cmdIf output is driven while in IDLE.

Optional Feature:
- UCTL_CMDARB_RR_EN defined: round-robin. On simultaneous requests, grant the master that is not last_owner; last_owner updates on every grant.
- Undefined: fixed priority, m0 always wins. last_owner is not implemented.

Decomposition:
- Package uctl_cmdarb_pkg:
  - state encoding: IDLE=2'b00, CMD=2'b01, WR=2'b10, RD=2'b11
  - owner encoding: M0=1'b0, M1=1'b1
  - ADDR_INCR default
- Sub-module uctl_rr_arb2: two-request picker with last_owner register (RR) or fixed priority, selected by the macro.

Test Plan:
- m0 write, addr 0x0920, len 3, wrValid always high, downstream acks → wrData_req cycles 2,3,4 at addresses 0x920/0x924/0x928; m0_done at cycle 5; err=0.
- m1 read, addr 0x0800, len 2, rdData_ack 1 cycle after req → rdValid at cycles 3 and 5, data 0xA5A5_0001/0xA5A5_0002; m1_done at cycle 6.
- m0 write, len 2, wrValid low for 3 cycles after word 1 → cmdIf_req re-issued with addr+4 on each stall cycle; the second word lands at start+4.
- m0_req and m1_req high together twice → RR_EN: grants m0 then m1; without the macro: m0 both times.
- m1 write to 0x0000_0100 (no ack in CMD) → m1_done=m1_err=1 at cycle 2; no wrData_req is ever driven.
- sw_rst during RD, word 2 of 4 → IDLE next cycle, trEn=0, no done pulse; a new m0 grant follows.
